// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared state type and default widths for the run_ctrl job initiator
package run_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, REQ, WAIT, DRAIN, FINISH} state_t;
  localparam int ADDR_W = 8;
  localparam int LEN_W = ADDR_W + 1;
  localparam int DATA_W = 8;
  localparam int TIMER_W = 16;
  localparam logic [TIMER_W-1:0] TO_CYC_DEF = 16'd4000;
endpackage

// File: rtl/run_ctrl_burst_counter.sv
// burst_counter: base+index address walker with last-word and empty flags
// ports: clk, reset (async active-low), load (latch base/len, zero index),
//        inc (advance index), base, len -> addr (wraps mod 2^AW), last, empty
module burst_counter #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          inc,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   len,
  output logic [AW-1:0] addr,
  output logic          last,
  output logic          empty
);
  logic [AW-1:0] base_q;
  logic [AW:0] len_q, idx, remaining;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      base_q <= '0;
      len_q <= '0;
      idx <= '0;
    end else if (load) begin
      base_q <= base;
      len_q <= len;
      idx <= '0;
    end else if (inc) idx <= idx + 1'b1;
  assign remaining = len_q - idx;
  assign addr = base_q + idx[AW-1:0];
  assign last = remaining == (AW+1)'(1);
  assign empty = remaining == '0;
endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: host-side initiator that preloads data memory, pulses core_req, waits for done, drains results
// ports: clk, reset (async active-low); start + ld/rd base/len job descriptor;
//        ld_valid/ld_data/ld_ready load stream; mem_* data-memory host port;
//        core_req/core_done core handshake; out_valid/out_data/out_last/out_ready result stream;
//        busy, timeout_err (sticky), job_done (one-cycle end pulse)
module run_ctrl import run_ctrl_pkg::*; #(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W,
  parameter int TO_W = TIMER_W,
  parameter logic [TO_W-1:0] TO_CYC = TO_CYC_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] ld_base,
  input  logic [AW:0]   ld_len,
  input  logic [AW-1:0] rd_base,
  input  logic [AW:0]   rd_len,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wr_dat,
  input  logic [DW-1:0] mem_rd_dat,
  output logic          core_req,
  input  logic          core_done,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  input  logic          out_ready,
  output logic          busy,
  output logic          timeout_err,
  output logic          job_done
);
  state_t state, nxt;
  logic [AW-1:0] ld_addr, rd_addr;
  logic ld_last, ld_empty, rd_last, rd_empty;
  logic [TO_W-1:0] to_cnt;
  logic armed, accept, take, fetch, done_ok, to_hit;
  assign accept = state == IDLE && start;
  assign take = out_valid && out_ready;
  // refill the single output slot whenever it is empty or being emptied this cycle
  assign fetch = state == DRAIN && !rd_empty && (!out_valid || out_ready);
  // armed only after core_done has been seen low, so a stale done level is ignored
  assign done_ok = core_done && armed;
  assign to_hit = to_cnt == TO_CYC - 1'b1;
  burst_counter #(.AW(AW)) u_ld (
    .clk(clk), .reset(reset), .load(accept), .inc(mem_wr_en),
    .base(ld_base), .len(ld_len), .addr(ld_addr), .last(ld_last), .empty(ld_empty)
  );
  burst_counter #(.AW(AW)) u_rd (
    .clk(clk), .reset(reset), .load(accept), .inc(fetch),
    .base(rd_base), .len(rd_len), .addr(rd_addr), .last(rd_last), .empty(rd_empty)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    busy = state != IDLE;
    ld_ready = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr = '0;
    mem_wr_dat = '0;
    core_req = 1'b0;
    job_done = 1'b0;
    case (state)
      IDLE: nxt = !start ? IDLE : ld_len == '0 ? REQ : LOAD;
      LOAD: begin
        ld_ready = !ld_empty;
        mem_wr_en = ld_valid && !ld_empty;
        mem_addr = ld_addr;
        mem_wr_dat = mem_wr_en ? ld_data : '0;
        nxt = mem_wr_en && ld_last ? REQ : LOAD;
      end
      REQ: begin
        core_req = 1'b1;
        nxt = WAIT;
      end
      WAIT: nxt = done_ok ? (rd_empty ? FINISH : DRAIN) : to_hit ? FINISH : WAIT;
      DRAIN: begin
        mem_addr = rd_addr;
        nxt = take && out_last ? FINISH : DRAIN;
      end
      FINISH: begin
        job_done = 1'b1;
        nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      to_cnt <= '0;
      armed <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      to_cnt <= state == WAIT ? to_cnt + 1'b1 : '0;
      armed <= state == WAIT ? armed || !core_done : 1'b0;
      if (accept) timeout_err <= 1'b0;
      else if (state == WAIT && !done_ok && to_hit) timeout_err <= 1'b1;
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
    end else if (fetch) begin
      out_valid <= 1'b1;
      out_data <= mem_rd_dat;
      out_last <= rd_last;
    end else if (take) begin
      out_valid <= 1'b0;
      out_last <= 1'b0;
    end
endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: randomized job-level checks of run_ctrl against a window/queue reference model
module tb_run_ctrl;
  localparam int TO = 16;
  logic clk = 0, rst_n = 0, start = 0;
  logic [7:0] ld_base = 0, rd_base = 0, ld_data = 0;
  logic [8:0] ld_len = 0, rd_len = 0;
  logic ld_valid = 0, core_done = 0, out_ready = 0;
  logic ld_ready, mem_wr_en, core_req, out_valid, out_last, busy, timeout_err, job_done;
  logic [7:0] mem_addr, mem_wr_dat, mem_rd_dat, out_data;
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic [7:0] ld_q [$];
  int n_chk = 0, n_pass = 0;

  run_ctrl #(.AW(8), .DW(8), .TO_W(16), .TO_CYC(16'(TO))) dut (
    .clk(clk), .reset(rst_n), .start(start), .ld_base(ld_base), .ld_len(ld_len),
    .rd_base(rd_base), .rd_len(rd_len), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_dat(mem_wr_dat),
    .mem_rd_dat(mem_rd_dat), .core_req(core_req), .core_done(core_done),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .timeout_err(timeout_err), .job_done(job_done)
  );

  always #5 clk = ~clk;
  assign mem_rd_dat = mem[mem_addr];
  always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_wr_dat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {ld_ready, mem_wr_en, mem_addr, mem_wr_dat, core_req, out_valid, out_data,
              out_last, busy, timeout_err, job_done}, 32'd0);
  endtask

  // One job: drives the streams and core_done, records what the DUT did, then compares the
  // record with the expected windows. Entered and left at posedge+1.
  task automatic run_job(input logic [7:0] lb, input int ll, input logic [7:0] rb, input int rl,
                         input int vp, input int rp, input int dl, input bit never, input int abort_at);
    logic [15:0] wr_q [$];
    logic [8:0] out_q [$];
    int k = 0, cyc = 0, w = 0, n_req = 0, n_wr;
    int req_cyc = -1, rise_cyc = -1, ov_cyc = -1, acc_cyc = -1, done_cyc = -1;
    bit fin = 0, stall = 0, aborted = 0;
    logic [7:0] held = 0;
    while (ld_q.size() < ll) ld_q.push_back(8'($urandom));
    start = 1; ld_base = lb; ld_len = 9'(ll); rd_base = rb; rd_len = 9'(rl);
    @(posedge clk); #1;
    start = 0;
    while (!fin && cyc < 3000) begin
      if (abort_at > 0 && k == abort_at) begin
        aborted = 1;
        break;
      end
      ld_valid = k < ll && $urandom_range(0, 99) < vp;
      ld_data = k < ll ? ld_q[k] : 8'($urandom);
      out_ready = $urandom_range(0, 99) < rp;
      start = $urandom_range(0, 7) == 0;
      ld_base = 8'($urandom); ld_len = 9'($urandom); rd_base = 8'($urandom); rd_len = 9'($urandom);
      if (req_cyc >= 0) begin
        core_done = !never && w >= dl;
        w++;
      end
      @(negedge clk);
      if (cyc == 0) begin
        chk("busy", busy, 1);
        chk("terr_clr", timeout_err, 0);
      end
      if (mem_wr_en) wr_q.push_back({mem_addr, mem_wr_dat});
      if (core_req) begin
        n_req++;
        if (req_cyc < 0) req_cyc = cyc;
      end
      if (req_cyc >= 0 && cyc > req_cyc && core_done && rise_cyc < 0) rise_cyc = cyc;
      if (out_valid && ov_cyc < 0) ov_cyc = cyc;
      if (stall) begin
        chk("hold_v", out_valid, 1);
        chk("hold_d", out_data, held);
      end
      stall = out_valid && !out_ready;
      held = out_data;
      if (out_valid && out_ready) begin
        out_q.push_back({out_last, out_data});
        acc_cyc = cyc;
      end
      if (job_done) begin
        done_cyc = cyc;
        fin = 1;
      end
      if (ld_valid && ld_ready) k++;
      @(posedge clk); #1;
      cyc++;
    end
    start = 0;
    if (aborted) begin
      ld_valid = 1;
      ld_data = ld_q[k];
      #2 rst_n = 0;
      #1 chk_zero("abort_outs");
      ld_valid = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      chk("abort_req", n_req, 0);
      n_wr = abort_at;
    end else begin
      ld_valid = 0;
      chk("job_end", fin, 1);
      if (!fin) begin
        rst_n = 0;
        #1 rst_n = 1;
      end
      n_wr = ll;
    end
    chk("wr_n", wr_q.size(), n_wr);
    for (int i = 0; i < n_wr && i < wr_q.size(); i++) chk("wr", wr_q[i], {8'(lb + i), ld_q[i]});
    for (int i = 0; i < n_wr; i++) ref_mem[8'(lb + i)] = ld_q[i];
    if (!aborted) begin
      chk("req_n", n_req, 1);
      chk("terr", timeout_err, never);
      if (never) begin
        chk("to_lat", done_cyc - req_cyc, TO + 1);
        chk("to_out", out_q.size(), 0);
      end else begin
        chk("out_n", out_q.size(), rl);
        for (int i = 0; i < rl && i < out_q.size(); i++)
          chk("out", out_q[i], {i == rl - 1, ref_mem[8'(rb + i)]});
        if (rl == 0) chk("done_lat", done_cyc - rise_cyc, 1);
        else begin
          chk("ov_lat", ov_cyc - rise_cyc, 2);
          chk("fin_lat", done_cyc - acc_cyc, 1);
        end
      end
      chk("idle", {busy, job_done}, 0);
    end
    ld_q.delete();
  endtask

  initial begin
    #12 chk_zero("rst");
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    // full-memory window first so every later read window hits known contents
    run_job(8'h37, 256, 8'hC0, 256, 70, 70, 4, 0, 0);
    ld_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    run_job(8'h10, 4, 8'h10, 4, 50, 100, 3, 0, 0);
    run_job(8'h00, 0, 8'h00, 0, 100, 100, 2, 0, 0);
    ld_q = '{8'h11, 8'h22, 8'h33};
    run_job(8'hFE, 3, 8'hFE, 3, 100, 50, 1, 0, 0);
    run_job(8'h20, 2, 8'h20, 5, 100, 100, 0, 1, 0);
    run_job(8'h40, 3, 8'h3E, 4, 100, 100, TO - 1, 0, 0);
    ld_q = '{8'h5A, 8'h5B, 8'h5C, 8'h5D};
    run_job(8'h50, 4, 8'h50, 4, 100, 100, 3, 0, 2);
    run_job(8'h60, 4, 8'h4E, 6, 50, 60, 5, 0, 0);
    repeat (14)
      run_job(8'($urandom), $urandom_range(0, 20), 8'($urandom), $urandom_range(0, 20),
              $urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(1, TO - 1),
              $urandom_range(0, 5) == 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
